keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Upstream stage of the keypad debouncer. Drives the 4 columns of a 4x4 matrix keypad
//   active-low one at a time and samples the 4 pulled-up rows through a 2-FF synchronizer.
//   On a hit it stops scanning, holds the column and reports key_pressed, row_idx and col_idx
//   (one-hot) to the debouncer. Runs on the 3 MHz system clock.
// PARAMETERS
//   SCAN_DIV        3000  cycles each column is driven before its rows are sampled (1 ms); must be >= 4
//   RELEASE_CYCLES  3000  cycles the latched row must read released before scanning resumes
// PORTS
//   clk          in   1  system clock, 3 MHz
//   rst          in   1  asynchronous, active-high reset
//   row_n        in   4  raw keypad rows, active-low, asynchronous to clk
//   col_n        out  4  column drive, active-low, exactly one bit low at all times
//   key_pressed  out  1  1 while the latched key reads pressed (HOLD state)
//   row_idx      out  4  one-hot row of the latched key; 0000 when no key is latched
//   col_idx      out  4  one-hot column of the latched key; 0000 when no key is latched
// BEHAVIOUR
//   - Reset (async assert, sync release): state=DRIVE, cnt=0, col_n=1110, sync FFs=1111,
//     key_pressed=0, row_idx=0000, col_idx=0000. Reset mid-operation returns outputs to these values immediately.
//   - rows = ~row_n after 2 synchronizer FFs; all decisions use synced rows only.
//   - cnt width = $clog2(max(SCAN_DIV,RELEASE_CYCLES)+1); cnt saturates, never wraps.
//   - DRIVE: cnt increments each cycle; at cnt==SCAN_DIV-1 -> SAMPLE.
//   - SAMPLE (1 cycle): if rows!=0: latch row (lowest set index wins), col_idx=~col_n,
//     -> HOLD, key_pressed=1 on the next cycle. Else rotate col_n 1110->1101->1011->0111->1110,
//     cnt=0, -> DRIVE. Idle column period = SCAN_DIV+1 cycles.
//   - HOLD: col_n frozen; key_pressed=1; row_idx/col_idx constant. Other rows ignored.
//     Latched row bit reads 0 -> RELEASE, cnt=0, key_pressed=0 next cycle.
//   - RELEASE: key_pressed=0, row_idx/col_idx retained, col_n frozen. Latched row reads 1 again
//     -> HOLD (key_pressed=1), cnt=0. Row reads 0 for RELEASE_CYCLES consecutive cycles ->
//     row_idx=col_idx=0000, rotate col_n to next column, cnt=0, -> DRIVE.
//   - Worst-case press-to-key_pressed latency: 4*(SCAN_DIV+1)+3 cycles after row_n settles.
//   - Outputs are registered; no combinational path from row_n to any output.
// CONFIGURATION
//   KEYPAD_GHOST_REJECT_EN defined: in SAMPLE, more than one row set on the driven column is
//     treated as no hit (scan rotates, key_pressed stays 0).
//   Not defined: multiple rows set -> lowest-index row latched, others ignored.
// TESTING
//   1 rst=1 mid-scan -> col_n=1110, key_pressed=0, row_idx=0000, col_idx=0000 same cycle.
//   2 row_n=1111 -> col_n steps 1110,1101,1011,0111,1110, each held SCAN_DIV+1 cycles.
//   3 keypad model: row 1 low only while col_n[2]=0 -> key_pressed=1, row_idx=0010,
//     col_idx=0100, col_n held at 1011 for the whole press.
//   4 release of 3 with three 100-cycle bounces -> key_pressed drops/returns per bounce; after
//     RELEASE_CYCLES clean: row_idx=col_idx=0000, col_n=0111, scan resumes.
//   5 rows 0 and 2 low on col 0 -> no macro: row_idx=0001, col_idx=0001;
//     KEYPAD_GHOST_REJECT_EN: key_pressed stays 0, col_n keeps rotating.
//   6 rst=1 during HOLD -> outputs to reset values asynchronously; after release, normal scan from col 0.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scanner for a 4x4 active-low matrix keypad.
// The columns are driven low one at a time. The pulled-up rows pass through a
// 2-FF synchronizer. When a key is found, scanning stops and the key is held.
// The column starts moving again only after the latched row has read released
// for RELEASE_CYCLES consecutive cycles.
// Optional feature: define KEYPAD_GHOST_REJECT_EN to ignore samples in which
// more than one row is active.
module keypad_scanner #(
  parameter int SCAN_DIV       = 3000,
  parameter int RELEASE_CYCLES = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_pressed,
  output logic [3:0] row_idx,
  output logic [3:0] col_idx
);

  localparam int CNT_MAX = (SCAN_DIV > RELEASE_CYCLES) ? SCAN_DIV : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {DRIVE, SAMPLE, HOLD, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       col_n_q, col_n_d;
  logic             key_pressed_q, key_pressed_d;
  logic [3:0]       row_idx_q, row_idx_d;
  logic [3:0]       col_idx_q, col_idx_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       rows;
  logic             sample_hit;
  logic             latched_hit;

  // Lowest active row wins when several rows are down on one column.
  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    casez (v)
      4'b???1: lowest_one = 4'b0001;
      4'b??10: lowest_one = 4'b0010;
      4'b?100: lowest_one = 4'b0100;
      4'b1000: lowest_one = 4'b1000;
      default: lowest_one = 4'b0000;
    endcase
  endfunction

  // Two-stage synchronizer. It idles at "all released" (1111) so that no
  // phantom hit appears out of reset.
  // NOTE: sequential state uses non-blocking assignments, so every flop sees
  // the pre-edge values of the other flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
    end
  end

  assign rows        = ~sync2_q;
  assign latched_hit = |(rows & row_idx_q);
  // The counter saturates instead of wrapping.
  assign cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef KEYPAD_GHOST_REJECT_EN
  logic multi_row;
  // More than one row active is treated as a ghosting pattern, not a key.
  assign multi_row  = (rows & (rows - 4'd1)) != 4'd0;
  assign sample_hit = (rows != 4'd0) && !multi_row;
`else
  assign sample_hit = (rows != 4'd0);
`endif

  // Next-state logic for the scan, hold and release sequence.
  // NOTE: every *_d signal starts from its hold value before the case, so no
  // path through the case can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    col_n_d       = col_n_q;
    key_pressed_d = key_pressed_q;
    row_idx_d     = row_idx_q;
    col_idx_d     = col_idx_q;
    case (state_q)
      DRIVE: begin
        cnt_d = cnt_inc;
        if (cnt_q == SCAN_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        cnt_d = '0;
        if (sample_hit) begin
          row_idx_d     = lowest_one(rows);
          col_idx_d     = ~col_n_q;
          key_pressed_d = 1'b1;
          state_d       = HOLD;
        end else begin
          col_n_d = {col_n_q[2:0], col_n_q[3]};
          state_d = DRIVE;
        end
      end
      HOLD: begin
        if (!latched_hit) begin
          cnt_d         = '0;
          key_pressed_d = 1'b0;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        if (latched_hit) begin
          // A bounce back to pressed restarts the release qualification.
          cnt_d         = '0;
          key_pressed_d = 1'b1;
          state_d       = HOLD;
        end else if (cnt_q == REL_LAST) begin
          cnt_d     = '0;
          row_idx_d = 4'b0000;
          col_idx_d = 4'b0000;
          col_n_d   = {col_n_q[2:0], col_n_q[3]};
          state_d   = DRIVE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = DRIVE;
        cnt_d   = '0;
      end
    endcase
  end

  // Scanner state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= DRIVE;
      cnt_q         <= '0;
      col_n_q       <= 4'b1110;
      key_pressed_q <= 1'b0;
      row_idx_q     <= 4'b0000;
      col_idx_q     <= 4'b0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_n_q       <= col_n_d;
      key_pressed_q <= key_pressed_d;
      row_idx_q     <= row_idx_d;
      col_idx_q     <= col_idx_d;
    end
  end

  assign col_n       = col_n_q;
  assign key_pressed = key_pressed_q;
  assign row_idx     = row_idx_q;
  assign col_idx     = col_idx_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: testbench for keypad_scanner. It uses short scan and
// release periods and a behavioural keypad that pulls rows low only while
// the pressed key's column is driven. It runs table vectors, hand-written
// bounce and reset sequences, and random presses.
module tb_keypad_scanner;

  localparam int S       = 8;
  localparam int R       = 20;
  localparam int LAT_MAX = 4 * (S + 1) + 3;

`ifdef KEYPAD_GHOST_REJECT_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  typedef struct {
    logic [3:0] rows;
    logic [1:0] col;
    logic       hit;
    logic [3:0] exp_row;
    logic [3:0] exp_col;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_pressed;
  logic [3:0] row_idx;
  logic [3:0] col_idx;

  logic       press_en   = 1'b0;
  logic [3:0] press_rows = 4'b0000;
  logic [1:0] press_col  = 2'd0;

  int vectors    = 0;
  int miscompares = 0;

  keypad_scanner #(.SCAN_DIV(S), .RELEASE_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_pressed(key_pressed), .row_idx(row_idx), .col_idx(col_idx)
  );

  always #5 clk = ~clk;

  // Keypad: pressed rows read low only while their column is driven low.
  always_comb row_n = (press_en && !col_n[press_col]) ? ~press_rows : 4'hF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Exactly one column must be driven low at every sampled point.
  always @(negedge clk) check("col_one_cold", 32'($countones(~col_n)), 32'd1);

  function automatic logic [3:0] lowest_row(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  function automatic vec_t make_vec(input logic [3:0] r, input logic [1:0] c);
    vec_t v;
    v.rows    = r;
    v.col     = c;
    v.hit     = !GHOST || ($countones(r) == 1);
    v.exp_row = v.hit ? lowest_row(r) : 4'b0000;
    v.exp_col = v.hit ? 4'(1 << c) : 4'b0000;
    return v;
  endfunction

  function automatic logic [3:0] drive_of(input logic [1:0] c);
    return ~(4'(1 << c));
  endfunction

  // Waits for key_pressed for up to 'bound' cycles and counts column steps.
  task automatic wait_key(input int bound, output int changes);
    logic [3:0] prev;
    prev    = col_n;
    changes = 0;
    for (int i = 0; i < bound && !key_pressed; i++) begin
      @(negedge clk);
      if (col_n !== prev) changes++;
      prev = col_n;
    end
  endtask

  // Waits up to 'bound' cycles for the current column to change and returns
  // the number of cycles taken.
  task automatic wait_col_change(input int bound, output int cycles);
    logic [3:0] prev;
    prev   = col_n;
    cycles = 0;
    while (col_n === prev && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int changes;
    press_rows = v.rows;
    press_col  = v.col;
    press_en   = 1'b1;
    wait_key(LAT_MAX + 2, changes);
    if (v.hit) begin
      check({tag, "_key_pressed"}, 32'(key_pressed), 32'd1);
      check({tag, "_row_idx"}, 32'(row_idx), 32'(v.exp_row));
      check({tag, "_col_idx"}, 32'(col_idx), 32'(v.exp_col));
      check({tag, "_col_n_held"}, 32'(col_n), 32'(drive_of(v.col)));
      repeat (12) @(negedge clk);
      check({tag, "_hold_col_n"}, 32'(col_n), 32'(drive_of(v.col)));
      check({tag, "_hold_key"}, 32'(key_pressed), 32'd1);
      press_en = 1'b0;
      for (int i = 0; i < R + 10 && row_idx != 4'b0000; i++) @(negedge clk);
      check({tag, "_released_row"}, 32'(row_idx), 32'd0);
      check({tag, "_released_col"}, 32'(col_idx), 32'd0);
      check({tag, "_released_key"}, 32'(key_pressed), 32'd0);
      check({tag, "_next_col"}, 32'(col_n), 32'(drive_of(v.col + 2'd1)));
    end else begin
      check({tag, "_ghost_no_key"}, 32'(key_pressed), 32'd0);
      check({tag, "_ghost_no_row"}, 32'(row_idx), 32'd0);
      check({tag, "_ghost_rotates"}, 32'(changes >= 4), 32'd1);
      press_en = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    vec_t       vecs [7];
    vec_t       rv;
    int         cyc;
    logic [3:0] exp_seq [5];

    vecs[0] = '{4'b0001, 2'd0, 1'b1, 4'b0001, 4'b0001};
    vecs[1] = '{4'b0010, 2'd2, 1'b1, 4'b0010, 4'b0100};
    vecs[2] = '{4'b0100, 2'd3, 1'b1, 4'b0100, 4'b1000};
    vecs[3] = '{4'b1000, 2'd1, 1'b1, 4'b1000, 4'b0010};
    vecs[4] = '{4'b0101, 2'd0, !GHOST, GHOST ? 4'b0000 : 4'b0001, GHOST ? 4'b0000 : 4'b0001};
    vecs[5] = '{4'b1100, 2'd3, !GHOST, GHOST ? 4'b0000 : 4'b0100, GHOST ? 4'b0000 : 4'b1000};
    vecs[6] = '{4'b1111, 2'd2, !GHOST, GHOST ? 4'b0000 : 4'b0001, GHOST ? 4'b0000 : 4'b0100};
    exp_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

    // Reset state.
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_col_n", 32'(col_n), 32'b1110);
    check("rst_key", 32'(key_pressed), 32'd0);
    check("rst_row_idx", 32'(row_idx), 32'd0);
    check("rst_col_idx", 32'(col_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle scan: each column is held for S+1 cycles, in order.
    for (int i = 0; i < 5; i++) begin
      wait_col_change(2 * (S + 1), cyc);
      check("scan_period", 32'(cyc), 32'(S + 1));
      check("scan_col", 32'(col_n), 32'(exp_seq[i]));
    end

    // Asynchronous reset in the middle of a scan.
    repeat (3) @(negedge clk);
    check("pre_rst_col", 32'(col_n), 32'b1101);
    #2 rst = 1'b1;
    #1;
    check("async_rst_col_n", 32'(col_n), 32'b1110);
    check("async_rst_key", 32'(key_pressed), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors.
    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Row 1 on column 2, then three bounces during release.
    press_rows = 4'b0010;
    press_col  = 2'd2;
    press_en   = 1'b1;
    wait_key(LAT_MAX + 2, cyc);
    check("bnc_press_key", 32'(key_pressed), 32'd1);
    check("bnc_press_row", 32'(row_idx), 32'b0010);
    check("bnc_press_col", 32'(col_idx), 32'b0100);
    repeat (5) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      press_en = 1'b0;
      repeat (2) @(negedge clk);
      check("bnc_drop_not_yet", 32'(key_pressed), 32'd1);
      @(negedge clk);
      check("bnc_drop", 32'(key_pressed), 32'd0);
      check("bnc_drop_row_kept", 32'(row_idx), 32'b0010);
      repeat (5) @(negedge clk);
      check("bnc_col_frozen", 32'(col_n), 32'b1011);
      press_en = 1'b1;
      repeat (3) @(negedge clk);
      check("bnc_return", 32'(key_pressed), 32'd1);
      repeat (4) @(negedge clk);
    end
    press_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_drop", 32'(key_pressed), 32'd0);
    repeat (R - 1) @(negedge clk);
    check("rel_still_latched", 32'(row_idx), 32'b0010);
    @(negedge clk);
    check("rel_row_cleared", 32'(row_idx), 32'd0);
    check("rel_col_cleared", 32'(col_idx), 32'd0);
    check("rel_next_col", 32'(col_n), 32'b0111);
    repeat (S) @(negedge clk);
    check("rel_scan_hold", 32'(col_n), 32'b0111);
    @(negedge clk);
    check("rel_scan_resume", 32'(col_n), 32'b1110);

    // Reset while a key is held.
    press_rows = 4'b0100;
    press_col  = 2'd1;
    press_en   = 1'b1;
    wait_key(LAT_MAX + 2, cyc);
    check("hold_before_rst", 32'(key_pressed), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("hold_rst_key", 32'(key_pressed), 32'd0);
    check("hold_rst_row", 32'(row_idx), 32'd0);
    check("hold_rst_col_idx", 32'(col_idx), 32'd0);
    check("hold_rst_col_n", 32'(col_n), 32'b1110);
    press_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (S) @(negedge clk);
    check("post_rst_col0", 32'(col_n), 32'b1110);
    @(negedge clk);
    check("post_rst_col1", 32'(col_n), 32'b1101);

    // Random presses against the reference model.
    for (int n = 0; n < 24; n++) begin
      rv = make_vec(4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)));
      apply_vec(rv, $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
